// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - shared constants and helpers for the parameterised FIFO
package fifo_param_pkg;

  localparam bit FWFT_REGISTERED  = 1'b0;
  localparam bit FWFT_FALLTHROUGH = 1'b1;

  // Occupancy runs 0..depth inclusive, so one extra code point is needed.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - FIFO request/response bundle with producer and FIFO views
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  localparam int CW = count_width(DEPTH);

  logic                  write_en;
  logic                  read_en;
  logic                  err_clear;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en, read_en, err_clear, data_in,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  write_en, read_en, err_clear, data_in,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_param_ctrl.sv
// rtl/fifo_param_ctrl.sv - FIFO pointers, occupancy, threshold flags and sticky errors
module fifo_param_ctrl
  import fifo_param_pkg::*;
#(
  parameter int  DEPTH    = 16,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = count_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write_en,
  input  logic          read_en,
  input  logic          err_clear,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] rd_idx,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          ovf_evt, udf_evt;

  // A full FIFO still takes a write when the same cycle pops a word.
  always_comb begin
    rd_acc     = read_en && !empty;
    wr_acc     = write_en && (!full || rd_acc);
    ovf_evt    = write_en && full && !rd_acc;
    udf_evt    = read_en && empty;
    wr_ptr_nxt = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      empty        <= (wr_ptr_nxt == rd_ptr_nxt);
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      // A fresh error wins over a simultaneous clear.
      overflow     <= ovf_evt || (overflow && !err_clear);
      underflow    <= udf_evt || (underflow && !err_clear);
    end
  end

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with registered or fall-through read
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = FWFT_REGISTERED
) (
  input logic         clock,
  input logic         reset,
  fifo_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;
  logic                  wr_acc, rd_acc;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic                  full, empty, almost_full, almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow, underflow;

  fifo_param_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .write_en     (bus.write_en),
    .read_en      (bus.read_en),
    .err_clear    (bus.err_clear),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wr_idx       (wr_idx),
    .rd_idx       (rd_idx),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is not cleared on reset; the pointer reset makes old words unreachable.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset) begin
      mem[wr_idx] <= bus.data_in;
    end
  end

  if (FWFT == FWFT_REGISTERED) begin : g_registered
    always_ff @(posedge clock) begin
      if (reset) begin
        dout   <= '0;
        dvalid <= 1'b0;
      end else begin
        dvalid <= rd_acc;
        if (rd_acc) begin
          dout <= mem[rd_idx];
        end
      end
    end
  end else begin : g_fallthrough
    // Head word is shown directly; an empty FIFO presents zero instead of stale storage.
    always_comb begin
      dout   = empty ? '0 : mem[rd_idx];
      dvalid = !empty;
    end
  end

  assign bus.data_out     = dout;
  assign bus.data_valid   = dvalid;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for registered and fall-through FIFOs
module tb_fifo_param;

  logic clock;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b0 ();
  fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b1 ();

  fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) dut_reg (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) dut_fwft (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    total_cnt    = 0;
    pass_cnt     = 0;
    reset        = 1'b1;
    b0.write_en  = 1'b0;
    b0.read_en   = 1'b0;
    b0.err_clear = 1'b0;
    b0.data_in   = '0;
    b1.write_en  = 1'b0;
    b1.read_en   = 1'b0;
    b1.err_clear = 1'b0;
    b1.data_in   = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_count", b0.count, 0);
    chk("rst_empty", b0.empty, 1);
    chk("rst_full", b0.full, 0);
    chk("rst_ae", b0.almost_empty, 1);
    chk("rst_af", b0.almost_full, 0);
    chk("rst_dv", b0.data_valid, 0);
    chk("rst_ovf", b0.overflow, 0);
    chk("rst_udf", b0.underflow, 0);
    chk("rst_dout", b0.data_out, 0);
    chk("rst_fwft_dv", b1.data_valid, 0);
    chk("rst_fwft_empty", b1.empty, 1);

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      b0.write_en = 1'b1;
      b0.data_in  = 8'(i);
      tick();
      chk($sformatf("fill_count_%0d", i), b0.count, i);
      chk($sformatf("fill_af_%0d", i), b0.almost_full, (i >= 14) ? 1 : 0);
      chk($sformatf("fill_ae_%0d", i), b0.almost_empty, (i <= 2) ? 1 : 0);
      chk($sformatf("fill_full_%0d", i), b0.full, (i == 16) ? 1 : 0);
    end

    // Simultaneous write and read while full
    b0.data_in = 8'd17;
    b0.read_en = 1'b1;
    tick();
    chk("wr_rd_full_count", b0.count, 16);
    chk("wr_rd_full_full", b0.full, 1);
    chk("wr_rd_full_dv", b0.data_valid, 1);
    chk("wr_rd_full_dout", b0.data_out, 8'd1);

    // Overflow: dropped write
    b0.read_en = 1'b0;
    b0.data_in = 8'hAA;
    tick();
    chk("ovf_set", b0.overflow, 1);
    chk("ovf_count", b0.count, 16);
    chk("ovf_dv", b0.data_valid, 0);
    chk("ovf_dout_hold", b0.data_out, 8'd1);
    b0.write_en  = 1'b0;
    b0.err_clear = 1'b1;
    tick();
    chk("ovf_clear", b0.overflow, 0);
    b0.err_clear = 1'b0;

    // Drain: 2..17, the 0xAA never appears
    for (int i = 2; i <= 17; i++) begin
      b0.read_en = 1'b1;
      tick();
      chk($sformatf("drain_dout_%0d", i), b0.data_out, i);
      chk($sformatf("drain_dv_%0d", i), b0.data_valid, 1);
      chk($sformatf("drain_count_%0d", i), b0.count, 17 - i);
    end
    chk("drain_empty", b0.empty, 1);
    chk("drain_ae", b0.almost_empty, 1);
    chk("drain_udf_none", b0.underflow, 0);
    b0.read_en = 1'b0;
    tick();
    chk("idle_dv", b0.data_valid, 0);
    chk("idle_dout_hold", b0.data_out, 8'd17);

    // Read on empty together with a write
    b0.read_en  = 1'b1;
    b0.write_en = 1'b1;
    b0.data_in  = 8'h55;
    tick();
    chk("udf_set", b0.underflow, 1);
    chk("udf_count", b0.count, 1);
    chk("udf_dv", b0.data_valid, 0);
    b0.write_en = 1'b0;
    tick();
    chk("udf_next_dout", b0.data_out, 8'h55);
    chk("udf_next_dv", b0.data_valid, 1);
    chk("udf_next_empty", b0.empty, 1);

    // Error coinciding with clear keeps flag set
    b0.err_clear = 1'b1;
    tick();
    chk("udf_clear_collide", b0.underflow, 1);
    b0.read_en = 1'b0;
    tick();
    chk("udf_clear", b0.underflow, 0);
    b0.err_clear = 1'b0;

    // Reset mid-operation with errors pending
    b0.read_en = 1'b1;
    tick();
    chk("pre_rst_udf", b0.underflow, 1);
    b0.read_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b0.write_en = 1'b1;
      b0.data_in  = 8'(8'h30 + i);
      tick();
    end
    b0.write_en = 1'b0;
    chk("pre_rst_count", b0.count, 5);
    b0.read_en = 1'b1;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    b0.read_en = 1'b0;
    chk("mid_rst_count", b0.count, 0);
    chk("mid_rst_empty", b0.empty, 1);
    chk("mid_rst_dv", b0.data_valid, 0);
    chk("mid_rst_ovf", b0.overflow, 0);
    chk("mid_rst_udf", b0.underflow, 0);
    chk("mid_rst_dout", b0.data_out, 0);
    b0.write_en = 1'b1;
    b0.data_in  = 8'h77;
    tick();
    b0.write_en = 1'b0;
    b0.read_en  = 1'b1;
    tick();
    b0.read_en = 1'b0;
    chk("post_rst_dout", b0.data_out, 8'h77);
    chk("post_rst_empty", b0.empty, 1);

    // Fall-through instance
    b1.write_en = 1'b1;
    b1.data_in  = 8'h11;
    tick();
    chk("fwft_dout_first", b1.data_out, 8'h11);
    chk("fwft_dv_first", b1.data_valid, 1);
    b1.data_in = 8'h22;
    tick();
    b1.write_en = 1'b0;
    chk("fwft_dout_hold", b1.data_out, 8'h11);
    chk("fwft_count", b1.count, 2);
    b1.read_en = 1'b1;
    tick();
    chk("fwft_dout_next", b1.data_out, 8'h22);
    chk("fwft_dv_next", b1.data_valid, 1);
    tick();
    b1.read_en = 1'b0;
    chk("fwft_empty", b1.empty, 1);
    chk("fwft_dv_empty", b1.data_valid, 0);
    chk("fwft_udf_none", b1.underflow, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 0: 0 = registered read mode, 1 = first-word-fall-through mode.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clock  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 write_en  in  1  write request for the current cycle.
REQ-010 read_en  in  1  read (pop) request for the current cycle.
REQ-011 err_clear  in  1  clears the sticky error flags.
REQ-012 data_in  in  DATA_WIDTH  write data.
REQ-013 data_out  out  DATA_WIDTH  read data.
REQ-014 data_valid  out  1  data_out qualifier.
REQ-015 full, empty  out  1 each  occupancy flags.
REQ-016 almost_full, almost_empty  out  1 each  threshold flags.
REQ-017 count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-018 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-019 A write is accepted when write_en=1 and either (full=0) or (full=1 and a read is accepted in the same cycle).
REQ-020 A read is accepted when read_en=1 and empty=0; a write in the same cycle never makes a read on an empty FIFO succeed.
REQ-021 An accepted write stores data_in at the write pointer; an accepted read advances the read pointer.
REQ-022 Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full = same index with the MSB differing; empty = pointers equal.
REQ-023 count +1 on a write only, -1 on a read only, unchanged when both or neither are accepted.
REQ-024 All flags and count are registered and reflect accepted operations on the next cycle edge.
REQ-025 FWFT=0: data_out is registered and is loaded with the head word on the edge that accepts the read; data_valid is 1 for exactly the cycle after each accepted read; data_out holds its value otherwise.
REQ-026 FWFT=1: data_out always shows the head word; data_valid = !empty; an accepted read exposes the next word in the following cycle.
REQ-027 A write attempt while full with no accepted read is dropped, storage is unchanged, and overflow is set.
REQ-028 A read attempt while empty is ignored, pointers are unchanged, and underflow is set.
REQ-029 overflow and underflow stay set until err_clear=1 or reset; an error that coincides with err_clear leaves the flag set.
REQ-030 almost_full and almost_empty are computed from the next-state count so that they align with count.

Reset
REQ-031 On reset=1 at an edge: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0, overflow=0, underflow=0, data_out=0.
REQ-032 Reset overrides every concurrent write, read, or err_clear; reset during operation discards all contents, and memory contents are not cleared.

Structure
REQ-033 Package fifo_param_pkg holds the FWFT mode constants and the count-width helper function.
REQ-034 Sub-module fifo_param_ctrl holds the pointers, count, flags, and error logic; the top level holds the storage array and the data_out path.

Verification
REQ-035 Reset, then write 1..16 (DEPTH=16) -> full=1 after the 16th write, count=16, almost_full from count 14; then read all 16 -> data 1..16 in order, empty=1.
REQ-036 Full FIFO, write_en=1 and read_en=1 for one cycle -> both accepted, count stays 16, and the new word appears last.
REQ-037 Full FIFO, write 0xAA with no read -> overflow=1, data is dropped, and the read sequence is unchanged; err_clear -> overflow=0.
REQ-038 Empty FIFO, read_en=1 together with write 0x55 -> underflow=1, count=1; the next read returns 0x55.
REQ-039 FWFT=1: write 0x11 -> data_out=0x11 and data_valid=1 before any read; after the read, empty=1 and data_valid=0.
REQ-040 Write 5 words, assert reset during a read -> the next cycle has count=0, empty=1, data_valid=0, and both error flags clear.
